// File: rtl/lane_compact_fifo_pkg.sv
// Shared constants and helpers for the lane compaction FIFO.
//   LANES : number of input lanes per group
//   LCW   : width of a per-group lane count (0..LANES)
//   ptr_width() : ceiling log2, used to derive the buffer pointer width
package lane_compact_fifo_pkg;

  localparam int unsigned LANES = 16;
  localparam int unsigned LCW   = 5;

  function automatic int unsigned ptr_width(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(depth)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/lane_popcount16.sv
// Combinational population count of a 16-bit lane mask.
//   i_mask  : lane valid mask
//   o_count : number of set bits (0..16)
module lane_popcount16
  import lane_compact_fifo_pkg::*;
(
  input  logic [LANES-1:0] i_mask,
  output logic [LCW-1:0]   o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < LANES; i++) begin
      o_count = o_count + LCW'(i_mask[i]);
    end
  end

endmodule

// File: rtl/lane_compact_fifo.sv
// Packs the valid lanes of a 16-lane group densely (lowest lane first) into a
// circular buffer and drains it one word per cycle over valid/ready.
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid / in_ready  : group handshake
//   in_lanes             : per-lane valid mask
//   in_data              : lane i at [i*WIDTH +: WIDTH]
//   out_valid / out_ready: output word handshake
//   out_data             : oldest buffered word
//   occupancy            : words stored in the buffer (staged words excluded)
module lane_compact_fifo
  import lane_compact_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = ptr_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [LANES-1:0]       in_lanes,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [AW:0]            occupancy
);

  logic [LCW-1:0]   w_in_count;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [LCW-1:0]   w_prefix    [LANES];
  logic [LANES-1:0] w_sel       [LANES];
  logic [WIDTH-1:0] w_slot_word [LANES];
  logic [AW+1:0]    w_free;

  logic [LCW-1:0]   r_stg_count;
  logic [WIDTH-1:0] r_stg_word [LANES];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_occ;
  logic [WIDTH-1:0] r_mem [DEPTH];

  lane_popcount16 u_popcount (
    .i_mask  (in_lanes),
    .o_count (w_in_count)
  );

  // Free space counts staged words as already committed, so an accepted group
  // always fits even before the previous one has been written.
  always_comb begin
    w_free   = (AW+2)'(DEPTH) - (AW+2)'(r_occ) - (AW+2)'(r_stg_count);
    in_ready = (w_free >= (AW+2)'(LANES));
  end

  assign w_in_fire  = in_valid & in_ready;
  assign out_valid  = (r_occ != '0);
  assign w_out_fire = out_valid & out_ready;
  assign out_data   = r_mem[r_rd_ptr];
  assign occupancy  = r_occ;

  // Number of set lanes strictly below lane i = destination slot of lane i.
  always_comb begin
    w_prefix[0] = '0;
    for (int i = 1; i < LANES; i++) begin
      w_prefix[i] = w_prefix[i-1] + LCW'(in_lanes[i-1]);
    end
  end

  // One-hot slot selects: slot k takes the lane whose prefix equals k.
  // An all-zero select marks an unused slot.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      for (int i = 0; i < LANES; i++) begin
        w_sel[k][i] = in_lanes[i] && (w_prefix[i] == LCW'(k));
      end
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_slot_word[k] = '0;
      for (int i = 0; i < LANES; i++) begin
        if (w_sel[k][i]) w_slot_word[k] = w_slot_word[k] | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stg_count <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
    end else begin
      r_stg_count <= w_in_fire ? w_in_count : '0;
      r_wr_ptr    <= r_wr_ptr + AW'(r_stg_count);
      r_rd_ptr    <= r_rd_ptr + AW'(w_out_fire);
      r_occ       <= r_occ + (AW+1)'(r_stg_count) - (AW+1)'(w_out_fire);
    end
  end

  // Data path is not reset; a zero stage count makes stale contents harmless.
  always_ff @(posedge clk) begin
    if (w_in_fire) r_stg_word <= w_slot_word;
    for (int k = 0; k < LANES; k++) begin
      if (LCW'(k) < r_stg_count) r_mem[r_wr_ptr + AW'(k)] <= r_stg_word[k];
    end
  end

endmodule
